// File: rtl/fast2slow_hs_tx_if.sv
// Fast-domain bundle between a pulse source, the handshake transmitter and the
// slow-domain receiver: event/ack/clear inputs, request/status outputs.
interface fast2slow_hs_tx_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 3
);
    logic [CH-1:0]       pulse_in;
    logic [CH-1:0]       ack_in;
    logic [CH-1:0]       ovf_clr;
    logic [CH-1:0]       req_out;
    logic [CH-1:0]       busy;
    logic [CH*CNT_W-1:0] pending;
    logic [CH-1:0]       ovf;

    modport master (
        output pulse_in,
        output ack_in,
        output ovf_clr,
        input  req_out,
        input  busy,
        input  pending,
        input  ovf
    );

    modport slave (
        input  pulse_in,
        input  ack_in,
        input  ovf_clr,
        output req_out,
        output busy,
        output pending,
        output ovf
    );
endinterface

// File: rtl/fast2slow_hs_tx.sv
// Per-channel pulse-to-4-phase-handshake source for fast-to-slow crossings.
// Pulses arriving mid-handshake are counted and replayed; a full counter drops and flags ovf.
module fast2slow_hs_tx #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic             clk1,
    input  logic             rst,
    fast2slow_hs_tx_if.slave hs
);
    // The state register is the last synchroniser stage, so only SYNC_STAGES-1 plain flops precede it.
    localparam int               ACK_FF  = SYNC_STAGES - 1;
    localparam logic [CNT_W-1:0] PMAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    logic [1:0]       rst_sync_q;
    logic [1:0]       rst_sync_d;
    logic             rst_int;

    logic [CH-1:0]    ack_sync_q [ACK_FF];
    logic [CH-1:0]    ack_sync_d [ACK_FF];
    logic [CH-1:0]    ack_m;

    state_e           state_q [CH];
    state_e           state_d [CH];
    logic [CNT_W-1:0] pend_q  [CH];
    logic [CNT_W-1:0] pend_d  [CH];
    logic [CH-1:0]    req_q;
    logic [CH-1:0]    req_d;
    logic [CH-1:0]    busy_q;
    logic [CH-1:0]    busy_d;
    logic [CH-1:0]    ovf_q;
    logic [CH-1:0]    ovf_d;
    logic [CH*CNT_W-1:0] pending_flat;

    // Reset release shifter: assertion is immediate, release lands on a clk1 edge.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b0};
    end

    // Reset release flops.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int = rst_sync_q[1];

    // Next values of the ack synchroniser chain.
    always_comb begin
        ack_sync_d[0] = hs.ack_in;
        for (int k = 1; k < ACK_FF; k++) begin
            ack_sync_d[k] = ack_sync_q[k-1];
        end
    end

    // Ack synchroniser flops.
    always_ff @(posedge clk1 or posedge rst_int) begin
        if (rst_int) begin
            for (int k = 0; k < ACK_FF; k++) begin
                ack_sync_q[k] <= {CH{1'b0}};
            end
        end else begin
            for (int k = 0; k < ACK_FF; k++) begin
                ack_sync_q[k] <= ack_sync_d[k];
            end
        end
    end

    assign ack_m = ack_sync_q[ACK_FF-1];

    // Per-channel handshake FSM, pending counter and sticky overflow next-state.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            pend_d[i]  = pend_q[i];
            ovf_d[i]   = ovf_q[i] & ~hs.ovf_clr[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (hs.pulse_in[i]) begin
                        state_d[i] = ST_REQ;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (ack_m[i]) begin
                        state_d[i] = ST_ACK;
                    end else begin
                        state_d[i] = ST_REQ;
                    end
                    if (hs.pulse_in[i] && (pend_q[i] != PMAX)) begin
                        pend_d[i] = pend_q[i] + CNT_ONE;
                    end else if (hs.pulse_in[i]) begin
                        ovf_d[i] = 1'b1;
                    end else begin
                        pend_d[i] = pend_q[i];
                    end
                end
                ST_ACK: begin
                    // Exit cycle: the new pulse and one queued entry cancel, so a full queue never drops here.
                    if (!ack_m[i]) begin
                        if (hs.pulse_in[i]) begin
                            state_d[i] = ST_REQ;
                            pend_d[i]  = pend_q[i];
                        end else if (pend_q[i] != CNT_ZERO) begin
                            state_d[i] = ST_REQ;
                            pend_d[i]  = pend_q[i] - CNT_ONE;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end else if (hs.pulse_in[i] && (pend_q[i] != PMAX)) begin
                        pend_d[i] = pend_q[i] + CNT_ONE;
                    end else if (hs.pulse_in[i]) begin
                        ovf_d[i] = 1'b1;
                    end else begin
                        state_d[i] = ST_ACK;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    pend_d[i]  = CNT_ZERO;
                end
            endcase
            req_d[i]  = (state_d[i] == ST_REQ);
            busy_d[i] = (state_d[i] != ST_IDLE) || (pend_d[i] != CNT_ZERO);
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk1 or posedge rst_int) begin
        if (rst_int) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= ST_IDLE;
                pend_q[i]  <= CNT_ZERO;
            end
            req_q  <= {CH{1'b0}};
            busy_q <= {CH{1'b0}};
            ovf_q  <= {CH{1'b0}};
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                pend_q[i]  <= pend_d[i];
            end
            req_q  <= req_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    // Flatten the per-channel counters onto the pending bus.
    always_comb begin
        pending_flat = {(CH*CNT_W){1'b0}};
        for (int i = 0; i < CH; i++) begin
            pending_flat[i*CNT_W +: CNT_W] = pend_q[i];
        end
    end

    assign hs.req_out = req_q;
    assign hs.busy    = busy_q;
    assign hs.ovf     = ovf_q;
    assign hs.pending = pending_flat;

endmodule

// File: tb/tb_fast2slow_hs_tx.sv
// Directed bench for fast2slow_hs_tx: manual ack control for cycle-exact checks,
// a per-channel auto-responder with programmable delay for counting handshakes.
`timescale 1ns/1ps
module tb_fast2slow_hs_tx;
    localparam int CH          = 4;
    localparam int CNT_W       = 3;
    localparam int SYNC_STAGES = 2;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    fast2slow_hs_tx_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

    fast2slow_hs_tx #(
        .CH(CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .hs   (bus.slave)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [CH-1:0] resp_en;
    logic [CH-1:0] ack_man;
    int            resp_dly [CH];
    int            hs_cnt   [CH];
    int            ph       [CH];
    int            cnt      [CH];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic wait_idle(input logic [CH-1:0] mask, input int budget, input string tag);
        int n;
        n = 0;
        while (((bus.busy & mask) != '0) && (n < budget)) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(bus.busy & mask), 32'd0);
    endtask

    function automatic logic [CNT_W-1:0] pend_of(input int ch);
        return bus.pending[ch*CNT_W +: CNT_W];
    endfunction

    // Slow-domain receiver model: manual level, or ack raised/dropped resp_dly cycles after req changes.
    initial begin
        bus.ack_in = '0;
        for (int i = 0; i < CH; i++) begin
            hs_cnt[i] = 0;
            ph[i]     = 0;
            cnt[i]    = 0;
        end
        forever begin
            @(posedge clk1);
            #2;
            for (int i = 0; i < CH; i++) begin
                if (!resp_en[i]) begin
                    ph[i]         = 0;
                    bus.ack_in[i] = ack_man[i];
                end else if (rst) begin
                    ph[i]         = 0;
                    bus.ack_in[i] = 1'b0;
                end else begin
                    case (ph[i])
                        0: if (bus.req_out[i]) begin cnt[i] = resp_dly[i]; ph[i] = 1; end
                        1: begin
                            cnt[i]--;
                            if (cnt[i] <= 0) begin bus.ack_in[i] = 1'b1; ph[i] = 2; end
                        end
                        2: if (!bus.req_out[i]) begin cnt[i] = resp_dly[i]; ph[i] = 3; end
                        default: begin
                            cnt[i]--;
                            if (cnt[i] <= 0) begin
                                bus.ack_in[i] = 1'b0;
                                hs_cnt[i]++;
                                ph[i] = 0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h [CH];
        logic [3:0] vec [7];
        int exp_hs [CH];

        bus.pulse_in = '0;
        bus.ovf_clr  = '0;
        resp_en      = '0;
        ack_man      = '0;
        for (int i = 0; i < CH; i++) resp_dly[i] = 1;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_req",  32'(bus.req_out), 32'd0);
        check_eq("rst_busy", 32'(bus.busy),    32'd0);
        check_eq("rst_pend", 32'(bus.pending), 32'd0);
        check_eq("rst_ovf",  32'(bus.ovf),     32'd0);
        rst = 1'b0;
        repeat (3) tick();
        check_eq("rel_req", 32'(bus.req_out), 32'd0);

        // Single pulse on ch0, receiver delay 3 both ways
        bus.pulse_in[0] = 1'b1;
        tick();
        bus.pulse_in[0] = 1'b0;
        check_eq("t1_req_rise", 32'(bus.req_out[0]), 32'd1);
        check_eq("t1_busy",     32'(bus.busy[0]),    32'd1);
        check_eq("t1_pend",     32'(pend_of(0)),     32'd0);
        repeat (3) tick();
        check_eq("t1_req_wait", 32'(bus.req_out[0]), 32'd1);
        ack_man[0] = 1'b1;
        tick();
        check_eq("t1_req_sync", 32'(bus.req_out[0]), 32'd1);
        tick();
        check_eq("t1_req_fall", 32'(bus.req_out[0]), 32'd0);
        check_eq("t1_busy_ack", 32'(bus.busy[0]),    32'd1);
        repeat (3) tick();
        ack_man[0] = 1'b0;
        tick();
        check_eq("t1_busy_sync", 32'(bus.busy[0]), 32'd1);
        tick();
        check_eq("t1_idle",     32'(bus.busy[0]), 32'd0);
        check_eq("t1_pend_end", 32'(pend_of(0)),  32'd0);

        // Stray ack while IDLE is ignored
        ack_man[0] = 1'b1;
        repeat (4) tick();
        check_eq("t1_stray_req",  32'(bus.req_out[0]), 32'd0);
        check_eq("t1_stray_busy", 32'(bus.busy[0]),    32'd0);
        ack_man[0] = 1'b0;
        repeat (3) tick();

        // Burst of 3 on ch1
        resp_dly[1] = 2;
        resp_en[1]  = 1'b1;
        h[1] = hs_cnt[1];
        bus.pulse_in[1] = 1'b1;
        tick();
        check_eq("t2_pend0", 32'(pend_of(1)),     32'd0);
        check_eq("t2_req",   32'(bus.req_out[1]), 32'd1);
        tick();
        check_eq("t2_pend1", 32'(pend_of(1)), 32'd1);
        tick();
        bus.pulse_in[1] = 1'b0;
        check_eq("t2_pend2", 32'(pend_of(1)), 32'd2);
        wait_idle(4'b0010, 200, "t2_timeout");
        check_eq("t2_hs",       32'(hs_cnt[1] - h[1]), 32'd3);
        check_eq("t2_pend_end", 32'(pend_of(1)),       32'd0);
        check_eq("t2_ovf",      32'(bus.ovf[1]),       32'd0);

        // Overflow on ch2 with ack held low
        bus.pulse_in[2] = 1'b1;
        repeat (8) tick();
        check_eq("t3_pend_full", 32'(pend_of(2)), 32'd7);
        check_eq("t3_ovf_pre",   32'(bus.ovf[2]), 32'd0);
        tick();
        check_eq("t3_ovf_set", 32'(bus.ovf[2]), 32'd1);
        tick();
        bus.pulse_in[2] = 1'b0;
        check_eq("t3_pend_sat", 32'(pend_of(2)),     32'd7);
        check_eq("t3_req",      32'(bus.req_out[2]), 32'd1);
        check_eq("t3_ovf_only", 32'(bus.ovf),        32'b0100);
        bus.ovf_clr[2] = 1'b1;
        tick();
        bus.ovf_clr[2] = 1'b0;
        check_eq("t3_ovf_clr", 32'(bus.ovf[2]), 32'd0);
        bus.pulse_in[2] = 1'b1;
        bus.ovf_clr[2]  = 1'b1;
        tick();
        bus.pulse_in[2] = 1'b0;
        bus.ovf_clr[2]  = 1'b0;
        check_eq("t3_set_wins", 32'(bus.ovf[2]), 32'd1);
        bus.ovf_clr[2] = 1'b1;
        tick();
        bus.ovf_clr[2] = 1'b0;
        check_eq("t3_ovf_clr2", 32'(bus.ovf[2]), 32'd0);
        resp_dly[2] = 1;
        h[2] = hs_cnt[2];
        resp_en[2] = 1'b1;
        wait_idle(4'b0100, 400, "t3_timeout");
        check_eq("t3_hs",       32'(hs_cnt[2] - h[2]), 32'd8);
        check_eq("t3_pend_end", 32'(pend_of(2)),       32'd0);
        check_eq("t3_ovf_end",  32'(bus.ovf[2]),       32'd0);

        // Pulse coincident with the ACK exit on ch3, empty then full queue
        bus.pulse_in[3] = 1'b1;
        tick();
        bus.pulse_in[3] = 1'b0;
        ack_man[3] = 1'b1;
        repeat (2) tick();
        check_eq("t4_in_ack", 32'(bus.req_out[3]), 32'd0);
        ack_man[3] = 1'b0;
        tick();
        check_eq("t4_exit_req", 32'(bus.req_out[3]), 32'd0);
        bus.pulse_in[3] = 1'b1;
        tick();
        bus.pulse_in[3] = 1'b0;
        check_eq("t4_rereq",  32'(bus.req_out[3]), 32'd1);
        check_eq("t4_pend0",  32'(pend_of(3)),     32'd0);
        bus.pulse_in[3] = 1'b1;
        repeat (7) tick();
        bus.pulse_in[3] = 1'b0;
        check_eq("t4_fill",     32'(pend_of(3)), 32'd7);
        check_eq("t4_ovf_fill", 32'(bus.ovf[3]), 32'd0);
        ack_man[3] = 1'b1;
        repeat (2) tick();
        ack_man[3] = 1'b0;
        tick();
        bus.pulse_in[3] = 1'b1;
        tick();
        bus.pulse_in[3] = 1'b0;
        check_eq("t4_pend_max", 32'(pend_of(3)),     32'd7);
        check_eq("t4_req_max",  32'(bus.req_out[3]), 32'd1);
        check_eq("t4_ovf_max",  32'(bus.ovf[3]),     32'd0);
        h[3] = hs_cnt[3];
        resp_dly[3] = 1;
        resp_en[3]  = 1'b1;
        wait_idle(4'b1000, 400, "t4_timeout");
        check_eq("t4_hs",  32'(hs_cnt[3] - h[3]), 32'd8);
        check_eq("t4_ovf", 32'(bus.ovf[3]),       32'd0);

        // All channels, differing receiver delays
        resp_dly[0] = 2;
        resp_dly[1] = 5;
        resp_dly[2] = 9;
        resp_dly[3] = 13;
        resp_en = 4'b1111;
        for (int i = 0; i < CH; i++) h[i] = hs_cnt[i];
        vec[0] = 4'b0001; vec[1] = 4'b0010; vec[2] = 4'b1100; vec[3] = 4'b0100;
        vec[4] = 4'b1000; vec[5] = 4'b1010; vec[6] = 4'b1000;
        exp_hs[0] = 1; exp_hs[1] = 2; exp_hs[2] = 2; exp_hs[3] = 4;
        for (int c = 0; c < 7; c++) begin
            bus.pulse_in = vec[c];
            tick();
        end
        bus.pulse_in = '0;
        check_eq("t5_pend_bus", 32'(bus.pending), 32'h648);
        check_eq("t5_req_bus",  32'(bus.req_out), 32'b1110);
        wait_idle(4'b1111, 2000, "t5_timeout");
        for (int i = 0; i < CH; i++) begin
            check_eq($sformatf("t5_hs_ch%0d", i), 32'(hs_cnt[i] - h[i]), 32'(exp_hs[i]));
        end
        check_eq("t5_ovf",  32'(bus.ovf),     32'd0);
        check_eq("t5_pend", 32'(bus.pending), 32'd0);

        // Asynchronous reset mid-handshake
        resp_en = '0;
        ack_man = '0;
        repeat (2) tick();
        bus.pulse_in = 4'b0011;
        repeat (3) tick();
        bus.pulse_in = 4'b0010;
        repeat (6) tick();
        bus.pulse_in = '0;
        check_eq("t6_pend_pre", 32'(pend_of(0)),     32'd2);
        check_eq("t6_ovf_pre",  32'(bus.ovf),        32'b0010);
        check_eq("t6_req_pre",  32'(bus.req_out),    32'b0011);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_req_async",  32'(bus.req_out), 32'd0);
        check_eq("t6_pend_async", 32'(bus.pending), 32'd0);
        check_eq("t6_busy_async", 32'(bus.busy),    32'd0);
        check_eq("t6_ovf_async",  32'(bus.ovf),     32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check_eq("t6_req_rel", 32'(bus.req_out), 32'd0);
        bus.pulse_in[0] = 1'b1;
        tick();
        bus.pulse_in[0] = 1'b0;
        check_eq("t6_req_new", 32'(bus.req_out), 32'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
